// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with one-bit-per-cycle shift-add multiply and restoring divide; results land DATA_W edges after accept.
// start_i is sampled only in IDLE/DONE and is dropped while busy_o is high; MTHI/MTLO complete in one edge.
module hilo_muldiv_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] LAST = 6'(DATA_W - 1);

   state_t              state;
   logic [5:0]          cnt;
   logic [DATA_W-1:0]   hi, lo, addend;
   logic [2*DATA_W-1:0] prod, prod_nxt, p_fix;
   logic                is_div, sgn1, sgn2, div_zero;

   logic                is_signed, s1_neg, s2_neg;
   logic [DATA_W-1:0]   mag1, mag2, diff, q_fix, r_fix;
   logic [DATA_W:0]     sum, shifted;

   always_comb begin
      is_signed = (op_i == 3'd0) || (op_i == 3'd2);
      s1_neg    = is_signed & src1_i[DATA_W-1];
      s2_neg    = is_signed & src2_i[DATA_W-1];
      mag1      = s1_neg ? -src1_i : src1_i;
      mag2      = s2_neg ? -src2_i : src2_i;

      // prod holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
      sum      = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, addend};
      shifted  = prod[2*DATA_W-1:DATA_W-1];
      diff     = shifted[DATA_W-1:0] - addend;
      prod_nxt = prod;
      if (!is_div) begin
         prod_nxt = prod[0] ? {sum, prod[DATA_W-1:1]} : {1'b0, prod[2*DATA_W-1:1]};
      end else if (shifted >= {1'b0, addend}) begin
         prod_nxt = {diff, prod[DATA_W-2:0], 1'b1};
      end else begin
         prod_nxt = {shifted[DATA_W-1:0], prod[DATA_W-2:0], 1'b0};
      end

      p_fix = (sgn1 ^ sgn2) ? -prod_nxt : prod_nxt;
      q_fix = (sgn1 ^ sgn2) ? -prod_nxt[DATA_W-1:0] : prod_nxt[DATA_W-1:0];
      r_fix = sgn1 ? -prod_nxt[2*DATA_W-1:DATA_W] : prod_nxt[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         prod     <= '0;
         addend   <= '0;
         is_div   <= 1'b0;
         sgn1     <= 1'b0;
         sgn2     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               prod <= prod_nxt;
               cnt  <= cnt + 6'd1;
               if (cnt == LAST) begin
                  state <= DONE;
                  if (is_div) begin
                     // divide by zero: remainder path already reproduces src1; quotient forced to all ones
                     hi <= r_fix;
                     lo <= div_zero ? '1 : q_fix;
                  end else begin
                     hi <= p_fix[2*DATA_W-1:DATA_W];
                     lo <= p_fix[DATA_W-1:0];
                  end
               end
            end
            default: begin
               state <= IDLE;
               if (start_i) begin
                  if (!op_i[2]) begin
                     state    <= RUN;
                     cnt      <= '0;
                     is_div   <= op_i[1];
                     sgn1     <= s1_neg;
                     sgn2     <= s2_neg;
                     div_zero <= (src2_i == '0);
                     addend   <= op_i[1] ? mag2 : mag1;
                     prod     <= {{DATA_W{1'b0}}, (op_i[1] ? mag1 : mag2)};
                  end else if (op_i == 3'd4) begin
                     hi <= src1_i;
                  end else if (op_i == 3'd5) begin
                     lo <= src1_i;
                  end
               end
            end
         endcase
      end
   end

   assign busy_o = (state == RUN);
   assign done_o = (state == DONE);
   assign hi_o   = hi;
   assign lo_o   = lo;

endmodule
